regfile_write_sequencer: RTL

//  Collects register write-back results from the ALU and memory paths, queues them in a small FIFO,
//  and drives the register file's single edge-triggered write port (address, data, enable). The

---
 rtl/regfile_write_sequencer_if.sv | 50 +++++
 rtl/regfile_write_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer_if.sv
// regfile_write_sequencer_if
//  Groups the write-back bus of the register file write sequencer.
//  It carries three groups of signals:
//  - the ALU and memory result handshakes (valid/ready/addr/data),
//  - the register file write port (wr_addr/wr_data/wr_en),
//  - the hazard outputs (pending_mask, the forwarding query and its result, busy).
//  Modports:
//  - master: the producer side. It offers results and issues forwarding queries.
//  - slave:  the sequencer itself.
interface regfile_write_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  localparam int NREGS = 2 ** ADDR_W;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [NREGS-1:0]  pending_mask;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              busy;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output fwd_addr,
    input  alu_ready, mem_ready,
    input  wr_addr, wr_data, wr_en,
    input  pending_mask, fwd_hit, fwd_data, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  fwd_addr,
    output alu_ready, mem_ready,
    output wr_addr, wr_data, wr_en,
    output pending_mask, fwd_hit, fwd_data, busy
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer
//  Queues register write-back results from the ALU and memory paths in a small FIFO. It then
//  drains them into an edge-triggered register file write port as SETUP / STROBE / HOLD
//  triple cycles. Each write gets exactly one rising edge of wr_en, with address and data
//  stable on both sides of that edge.
//  The block also exports, for decode-stage hazard logic:
//  - pending_mask: one bit per register with a queued or in-flight write,
//  - a forwarding lookup (fwd_addr in, fwd_hit/fwd_data out).
//  Ports:
//  - clk:   clock; all state updates on the rising edge.
//  - rst_n: asynchronous, active-low reset.
//  - bus:   slave side of regfile_write_sequencer_if. It carries the ALU/memory
//           handshakes, the write port, and the hazard outputs.
module regfile_write_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  regfile_write_sequencer_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              wr_en_r;

  logic [NREGS-1:0]  pending;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [PTR_W-1:0]  slot;

  // Full is the registered occupancy at the start of the cycle, so a pop in the same cycle
  // never frees a slot for that cycle's enqueue. Memory has fixed priority over the ALU.
  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;
  assign push          = !full && (bus.mem_valid || bus.alu_valid);
  assign push_addr     = bus.mem_valid ? bus.mem_addr : bus.alu_addr;
  assign push_data     = bus.mem_valid ? bus.mem_data : bus.alu_data;

  // FIFO payload storage. It needs no reset: slots are only read when the count marks
  // them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy. Reset discards every queued write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Drain FSM next state and pop decision. The head is popped only from IDLE or HOLD,
  // which gives the fixed three-cycle SETUP/STROBE/HOLD pattern per write.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = STROBE;
      STROBE: state_next = HOLD;
      HOLD: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered write port.
  // - Address and data load only on a pop, so they are frozen through SETUP..HOLD and
  //   keep their last value in IDLE.
  // - wr_en is high exactly for the STROBE cycle.
  // - Asynchronous reset drops wr_en at once. That is a falling edge, so it cannot cause
  //   a spurious write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_r <= '0;
      wr_data_r <= '0;
      wr_en_r   <= 1'b0;
    end else begin
      wr_en_r <= (state_next == STROBE);
      if (pop) begin
        wr_addr_r <= addr_q[rd_ptr];
        wr_data_r <= data_q[rd_ptr];
      end
    end
  end

  // Pending mask and forwarding lookup.
  // - The in-flight entry is considered first, so it is the lowest-priority source.
  // - FIFO entries are then scanned oldest to youngest, so the youngest match overwrites
  //   older ones.
  always_comb begin
    pending  = '0;
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    if (state != IDLE) begin
      pending[wr_addr_r] = 1'b1;
      if (wr_addr_r == bus.fwd_addr) begin
        hit      = 1'b1;
        hit_data = wr_data_r;
      end
    end
    for (int age = 0; age < DEPTH; age++) begin
      slot = rd_ptr + PTR_W'(age);
      if (CNT_W'(age) < count) begin
        pending[addr_q[slot]] = 1'b1;
        if (addr_q[slot] == bus.fwd_addr) begin
          hit      = 1'b1;
          hit_data = data_q[slot];
        end
      end
    end
  end

  assign bus.wr_addr      = wr_addr_r;
  assign bus.wr_data      = wr_data_r;
  assign bus.wr_en        = wr_en_r;
  assign bus.pending_mask = pending;
  assign bus.fwd_hit      = hit;
  assign bus.fwd_data     = hit_data;
  assign bus.busy         = !empty || (state != IDLE);
endmodule
